// File: rtl/sram_controller_pkg.sv
// Shared widths, state encodings and address helper for the 32-bit to 16-bit SRAM bridge.
// The word index helper maps a byte address to a 17-bit SRAM word slot, wrapping modulo 2^17.
package sram_controller_pkg;

    localparam int ADDRESS_LEN   = 32;
    localparam int REGISTER_LEN  = 32;
    localparam int SRAM_ADDR_LEN = 18;
    localparam int SRAM_DATA_LEN = 16;
    localparam int SRAM_IDX_LEN  = SRAM_ADDR_LEN - 1;

    localparam logic [ADDRESS_LEN-1:0] DEFAULT_BASE_ADDR = 32'd1024;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WR_LO = 3'd1;
    localparam logic [2:0] ST_WR_HI = 3'd2;
    localparam logic [2:0] ST_RD_LO = 3'd3;
    localparam logic [2:0] ST_RD_HI = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_WR_LO = ST_WR_LO,
        S_WR_HI = ST_WR_HI,
        S_RD_LO = ST_RD_LO,
        S_RD_HI = ST_RD_HI,
        S_DONE  = ST_DONE
    } state_t;

    // Each 32-bit word occupies two consecutive 16-bit SRAM locations.
    function automatic logic [SRAM_IDX_LEN-1:0] word_index(
        input logic [ADDRESS_LEN-1:0] address,
        input logic [ADDRESS_LEN-1:0] base
    );
        return SRAM_IDX_LEN'((address - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits single-cycle 32-bit MEM-stage loads/stores into two timed 16-bit SRAM half-accesses.
// ready drops in the request cycle and rises for exactly one DONE cycle when the access ends.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [ADDRESS_LEN-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int                     WAIT_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDRESS_LEN-1:0]   address,
    input  logic [REGISTER_LEN-1:0]  write_data,
    output logic [REGISTER_LEN-1:0]  read_data,
    output logic                     ready,
    inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_OE_N,
    output logic                     SRAM_UB_N,
    output logic                     SRAM_LB_N,
    output logic [2:0]               o_dbg_state
);

    // WAIT_CYCLES is meaningful only in 2..15: the 4-bit counter and the one-cycle hold need it.
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] CNT_HOLD = 4'(WAIT_CYCLES - 2);

    state_t                    r_state;
    logic [3:0]                r_cnt;
    logic [SRAM_IDX_LEN-1:0]   r_idx;
    logic [SRAM_DATA_LEN-1:0]  r_wdata_hi;
    logic [REGISTER_LEN-1:0]   r_read_data;
    logic                      r_we_n;
    logic                      r_dq_oe;
    logic [SRAM_DATA_LEN-1:0]  r_dq_out;
    logic [SRAM_ADDR_LEN-1:0]  r_sram_addr;

    logic [SRAM_IDX_LEN-1:0]   w_req_idx;
    logic                      w_last;

    assign w_req_idx = word_index(address, BASE_ADDR);
    assign w_last    = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_wdata_hi  <= '0;
            r_read_data <= '0;
            r_we_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
            r_sram_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (wr_en) begin
                        r_state     <= S_WR_LO;
                        r_idx       <= w_req_idx;
                        r_wdata_hi  <= write_data[31:16];
                        r_sram_addr <= {w_req_idx, 1'b0};
                        r_dq_out    <= write_data[15:0];
                        r_dq_oe     <= 1'b1;
                        r_we_n      <= 1'b0;
                    end else if (rd_en) begin
                        r_state     <= S_RD_LO;
                        r_idx       <= w_req_idx;
                        r_sram_addr <= {w_req_idx, 1'b0};
                    end
                end

                // WE_N is released one cycle before leaving the half so data is held past the rising edge.
                S_WR_LO, S_WR_HI: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_state == S_WR_LO) begin
                            r_state     <= S_WR_HI;
                            r_sram_addr <= {r_idx, 1'b1};
                            r_dq_out    <= r_wdata_hi;
                            r_we_n      <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_dq_oe <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == CNT_HOLD) begin
                            r_we_n <= 1'b1;
                        end
                    end
                end

                S_RD_LO, S_RD_HI: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_state == S_RD_LO) begin
                            r_state           <= S_RD_HI;
                            r_read_data[15:0] <= SRAM_DQ;
                            r_sram_addr       <= {r_idx, 1'b1};
                        end else begin
                            r_state            <= S_DONE;
                            r_read_data[31:16] <= SRAM_DQ;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end

                // Requests are ignored here so a held request is only re-accepted from IDLE.
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ready = 1'b0;
        if (r_state == S_IDLE) begin
            ready = ~(wr_en | rd_en);
        end else if (r_state == S_DONE) begin
            ready = 1'b1;
        end
    end

    assign SRAM_DQ     = r_dq_oe ? r_dq_out : {SRAM_DATA_LEN{1'bz}};
    assign SRAM_ADDR   = r_sram_addr;
    assign SRAM_WE_N   = r_we_n;
    assign SRAM_CE_N   = 1'b0;
    assign SRAM_OE_N   = 1'b0;
    assign SRAM_UB_N   = 1'b0;
    assign SRAM_LB_N   = 1'b0;
    assign read_data   = r_read_data;
    assign o_dbg_state = r_state;

endmodule
